alu_share_arbiter: RTL
======================

# alu_share_arbiter

Two-requester round-robin arbiter sharing one signed select/add/subtract datapath. Each requester presents operands and an op code on a valid/ready channel. The block grants one requester per cycle, computes the registered result, and returns it on a single valid/ready result channel tagged with the requester ID. It sits between the control engines and the shared arithmetic stage, so neither engine needs its own adder.

## Interface
- DW, 8, operand width in bits; results are DW+1 bits.

- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 handshake accept
- req0_a, req0_b  in  DW each  requester 0 signed operands
- req0_sel  in  2  requester 0 op code
- req1_valid, req1_ready, req1_a, req1_b, req1_sel  same as requester 0, for requester 1
- res_valid  out  1  result held
- res_ready  in  1  consumer accepts result
- res_data  out  DW+1  signed result
- res_id  out  1  requester that issued the result
- busy  out  1  res_valid OR any req*_valid

## Operation
- Op codes, with operands sign-extended to DW+1 bits first:
  - 00: a
  - 01: b
  - 10: a+b
  - 11: a−b
- Full precision: DW+1 bits never overflow for DW-bit operands.
- State machine:
  - EMPTY: res_valid=0.
  - FULL: res_valid=1.
  - EMPTY→FULL on an accept.
  - FULL→EMPTY on res_ready with no accept.
  - FULL→FULL on res_ready with a simultaneous accept (back-to-back), or when there is no res_ready.
- Slot free condition: `free = !res_valid | res_ready`.
- Arbitration is combinational on the current-cycle valids:
  - Only one valid: that requester is granted.
  - Both valid: the requester whose ID differs from the priority pointer `last` is granted.
  - `last` resets to 1, so requester 0 wins first.
- Ready signals: `reqN_ready = grantN & free`. The ready of the non-granted requester is 0.
- Handshake (accept) occurs when `reqN_valid & reqN_ready` is high. On accept:
  - res_data ← the op result.
  - res_id ← N.
  - `last` ← N.
- `last` updates only on accept.
- Requesters must hold a/b/sel stable while valid and not ready. Dropping valid before accept is allowed; no operation is lost or duplicated.
- While FULL and res_ready=0: res_data and res_id hold, and no accept occurs.

## Timing
- Reset values: res_valid=0, res_data=0, res_id=0, `last`=1, busy follows its inputs. During rst, req0_ready=req1_ready=0.
- Latency: accept at edge N → res_valid=1 and result visible after edge N (available to the consumer in cycle N+1).
- Throughput: one operation per cycle with res_ready held high.
- Fairness: both requesters continuously valid alternate 0,1,0,1…; worst-case wait is one grant.
- Simultaneous res_ready and new accept: the old result retires and the new result loads on the same edge, with no bubble.
- Reset mid-operation: rst dominates all other inputs at the edge. The held result is discarded and pending requests are not accepted that cycle.

## Configuration
- ALU_SAT_EN defined: the ops 10 and 11 results are clamped to the DW-bit signed range [−2^(DW−1), 2^(DW−1)−1] and then sign-extended to DW+1. Ops 00 and 01 are unaffected.
- ALU_SAT_EN undefined: full-precision DW+1 results, no clamping.

## Test plan
- Reset: hold rst 2 cycles with req0_valid=1 → both readies 0, res_valid=0, res_data=9'h000. After release, first accept is req0.
- Arithmetic, DW=8, single requester 0, res_ready=1:
  - a=100, b=50, sel=10 → res_data=150 (9'h096), res_id=0, one cycle after accept.
  - a=−128, b=127, sel=11 → −255 (9'h101).
  - a=−5, sel=00 → 9'h1FB.
- Saturation (ALU_SAT_EN):
  - a=100, b=50, sel=10 → 127 (9'h07F).
  - a=−128, b=127, sel=11 → −128 (9'h180).
  - sel=01, b=−1 → 9'h1FF.
- Round-robin: both valid for 6 cycles with res_ready=1 → res_id sequence 0,1,0,1,0,1, one result per cycle, each matching its requester's operands.
- Backpressure: res_ready=0 for 3 cycles while FULL with both valid → both readies 0, res_data/res_id stable. Raise res_ready → the held result retires and the next grant loads on the same edge.
- Reset mid-stream: assert rst for 1 cycle while FULL with req1 valid → res_valid=0 next cycle, `last`=1. After release with both valid, req0 is granted first.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: two-requester round-robin arbiter sharing one signed select/add/subtract stage
// Ports: clk, rst (sync, active-high); req0_*/req1_* valid/ready operand channels (a, b, sel);
//        res_valid/res_ready/res_data/res_id result channel; busy = res_valid | any request valid.
// Option: define ALU_SAT_EN to clamp add/subtract results to the DW-bit signed range.
module alu_share_arbiter #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0_valid,
   output logic          req0_ready,
   input  logic [DW-1:0] req0_a,
   input  logic [DW-1:0] req0_b,
   input  logic [1:0]    req0_sel,
   input  logic          req1_valid,
   output logic          req1_ready,
   input  logic [DW-1:0] req1_a,
   input  logic [DW-1:0] req1_b,
   input  logic [1:0]    req1_sel,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [DW:0]   res_data,
   output logic          res_id,
   output logic          busy
);
   typedef enum logic {EMPTY, FULL} state_t;
   state_t state;
   logic last, free, grant0, grant1, acc0, acc1;
   logic [DW-1:0] a, b;
   logic [1:0] sel;
   logic [DW:0] ea, eb, raw, op_res;
   assign res_valid = state == FULL;
   assign busy = res_valid | req0_valid | req1_valid;
   assign free = !res_valid | res_ready;
   // on contention the requester that did not win last time goes first
   assign grant0 = req0_valid & (!req1_valid | last);
   assign grant1 = req1_valid & (!req0_valid | !last);
   assign req0_ready = grant0 & free & !rst;
   assign req1_ready = grant1 & free & !rst;
   assign acc0 = req0_valid & req0_ready;
   assign acc1 = req1_valid & req1_ready;
   assign a = grant1 ? req1_a : req0_a;
   assign b = grant1 ? req1_b : req0_b;
   assign sel = grant1 ? req1_sel : req0_sel;
   always_comb begin
      ea = {a[DW-1], a};
      eb = {b[DW-1], b};
      raw = sel == 2'b00 ? ea : sel == 2'b01 ? eb : sel == 2'b10 ? ea + eb : ea - eb;
`ifdef ALU_SAT_EN
      // top two bits disagree exactly when the value left the DW-bit signed range
      op_res = (sel[1] && raw[DW] != raw[DW-1]) ?
               (raw[DW] ? {2'b11, {(DW-1){1'b0}}} : {2'b00, {(DW-1){1'b1}}}) : raw;
`else
      op_res = raw;
`endif
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= EMPTY;
         res_data <= '0;
         res_id <= 1'b0;
         last <= 1'b1;
      end else if (acc0 | acc1) begin
         state <= FULL;
         res_data <= op_res;
         res_id <= acc1;
         last <= acc1;
      end else if (res_ready) begin
         state <= EMPTY;
      end
   end
endmodule
